// File: rtl/mips_uart_tx_port_if.sv
// Data-memory bus bundle seen by the UART TX port: address, store data, strobes, status read-back.
// No latency of its own; ReadData is produced combinationally by the slave.
// No flow control: the core never stalls, so full-FIFO stores are dropped and flagged by the slave.
interface mips_uart_tx_port_if;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadData;

   modport master (
      output Address, WriteData, MemWrite, MemRead,
      input  ReadData
   );

   modport slave (
      input  Address, WriteData, MemWrite, MemRead,
      output ReadData
   );
endinterface

// File: rtl/mips_uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: stores to TX_ADDR queue a byte, loads from STATUS_ADDR return flags.
// Latency: a store into an empty FIFO is popped on the next edge and the start bit appears with it; 10*CLKS_PER_BIT cycles per frame.
// Backpressure: none toward the core; a store to a full FIFO (with no pop that cycle) is dropped and sets sticky overflow.
module mips_uart_tx_port #(
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [31:0] TX_ADDR      = 32'h1001_0024,
   parameter logic [31:0] STATUS_ADDR  = 32'h1001_0028
) (
   input  logic                 clk,
   input  logic                 reset,
   mips_uart_tx_port_if.slave   bus,
   output logic                 TxSerial,
   output logic                 TxBusy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t             state, state_next;
   logic [TMR_W-1:0]   timer, timer_next;
   logic [2:0]         bit_idx, bit_next;
   logic [7:0]         shift, shift_next;
   logic               tx_next;
   logic               pop;

   logic [7:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   head, tail;
   logic [CNT_W-1:0]   count;
   logic               overflow;

   logic               full;
   logic               push_req;
   logic               push;
   logic               ovf_set;
   logic               ovf_clr;
   logic               status_rd;
   logic               tc;
   logic               unused_wdata;

   // Only the low byte of store data is meaningful to a UART.
   assign unused_wdata = ^bus.WriteData[31:8];

   assign full      = (count == CNT_W'(FIFO_DEPTH));
   assign push_req  = bus.MemWrite && (bus.Address == TX_ADDR);
   assign push      = push_req && (!full || pop);
   assign ovf_set   = push_req && full && !pop;
   assign ovf_clr   = bus.MemWrite && (bus.Address == STATUS_ADDR);
   assign status_rd = bus.MemRead && (bus.Address == STATUS_ADDR);
   assign tc        = (timer == TMR_W'(CLKS_PER_BIT - 1));

   assign TxBusy       = (state != IDLE) || (count != '0);
   assign bus.ReadData = status_rd ? {29'b0, overflow, full, TxBusy} : 32'h0;

   // Frame sequencing: bit timer, state advance, FIFO pop and next line level.
   always_comb begin
      state_next = state;
      timer_next = timer;
      bit_next   = bit_idx;
      shift_next = shift;
      pop        = 1'b0;
      tx_next    = 1'b1;

      case (state)
         IDLE: begin
            timer_next = '0;
            if (count != '0) begin
               pop        = 1'b1;
               shift_next = mem[head];
               bit_next   = 3'd0;
               state_next = START;
            end
         end
         START: begin
            if (tc) begin
               timer_next = '0;
               state_next = DATA;
            end else begin
               timer_next = timer + TMR_W'(1);
            end
         end
         DATA: begin
            if (tc) begin
               timer_next = '0;
               shift_next = {1'b0, shift[7:1]};
               if (bit_idx == 3'd7) begin
                  state_next = STOP;
               end else begin
                  bit_next = bit_idx + 3'd1;
               end
            end else begin
               timer_next = timer + TMR_W'(1);
            end
         end
         STOP: begin
            if (tc) begin
               timer_next = '0;
               // Chain straight into the next start bit so frames stay contiguous.
               if (count != '0) begin
                  pop        = 1'b1;
                  shift_next = mem[head];
                  bit_next   = 3'd0;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               timer_next = timer + TMR_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase

      // Line level is registered, so derive it from where the FSM lands.
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
         default: tx_next = 1'b1;
      endcase
   end

   // State, line, FIFO pointers and overflow flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         timer    <= '0;
         bit_idx  <= 3'd0;
         shift    <= 8'h00;
         TxSerial <= 1'b1;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_next;
         timer    <= timer_next;
         bit_idx  <= bit_next;
         shift    <= shift_next;
         TxSerial <= tx_next;
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (ovf_clr) begin
            overflow <= 1'b0;
         end else if (ovf_set) begin
            overflow <= 1'b1;
         end
      end
   end

   // FIFO storage; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem[tail] <= bus.WriteData[7:0];
      end
   end

endmodule

// File: tb/tb_mips_uart_tx_port.sv
// Self-checking bench for mips_uart_tx_port: abstract queue/timeline model plus frame-decoding scoreboard.
// Inputs change 1 time unit after each rising edge; all checks happen on the falling edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_mips_uart_tx_port;

   localparam int          C  = 4;
   localparam int          D  = 4;
   localparam logic [31:0] TX = 32'h1001_0024;
   localparam logic [31:0] ST = 32'h1001_0028;
   localparam logic [31:0] OTHER = 32'h1001_0020;

   logic clk = 1'b0;
   logic reset;
   logic tx_serial;
   logic tx_busy;

   mips_uart_tx_port_if bus_if ();

   mips_uart_tx_port #(
      .CLKS_PER_BIT (C),
      .FIFO_DEPTH   (D),
      .TX_ADDR      (TX),
      .STATUS_ADDR  (ST)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus_if.slave),
      .TxSerial (tx_serial),
      .TxBusy   (tx_busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: queue of accepted bytes plus cycles left in the frame on the wire.
   logic [7:0] q[$];
   logic [7:0] exp_q[$];
   logic [7:0] cur;
   int         rem = 0;
   logic       ovf = 1'b0;
   int         rst_gen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update at each rising edge using the inputs presented for that edge.
   always @(posedge clk) begin
      logic pop_now;
      logic was_full;
      if (reset) begin
         q.delete();
         exp_q.delete();
         rem = 0;
         ovf = 1'b0;
         rst_gen++;
      end else begin
         was_full = (q.size() == D);
         pop_now  = (rem <= 1) && (q.size() != 0);
         if (pop_now) begin
            cur = q.pop_front();
            rem = 10 * C;
         end else if (rem > 0) begin
            rem--;
         end
         if (bus_if.MemWrite && bus_if.Address == TX) begin
            if (!was_full || pop_now) begin
               q.push_back(bus_if.WriteData[7:0]);
               exp_q.push_back(bus_if.WriteData[7:0]);
            end else begin
               ovf = 1'b1;
            end
         end
         if (bus_if.MemWrite && bus_if.Address == ST) ovf = 1'b0;
      end
   end

   // Per-cycle comparison of line level, busy flag and status read data.
   always @(negedge clk) begin
      logic       e_busy, e_line;
      logic [31:0] e_rd;
      int el, slot;
      e_busy = (rem != 0) || (q.size() != 0);
      if (rem == 0) begin
         e_line = 1'b1;
      end else begin
         el   = 10 * C - rem;
         slot = el / C;
         if (slot == 0)      e_line = 1'b0;
         else if (slot <= 8) e_line = cur[slot-1];
         else                e_line = 1'b1;
      end
      e_rd = (bus_if.MemRead && bus_if.Address == ST) ?
             {29'b0, ovf, (q.size() == D), e_busy} : 32'h0;
      check("txserial", {31'b0, tx_serial}, {31'b0, e_line});
      check("txbusy",   {31'b0, tx_busy},   {31'b0, e_busy});
      check("readdata", bus_if.ReadData,    e_rd);
   end

   // Scoreboard monitor: decode each frame off the line and match against accepted bytes.
   initial begin
      int gen;
      logic [7:0] data;
      logic stop_bit;
      logic [7:0] want;
      forever begin
         @(negedge clk);
         if (!reset && tx_serial === 1'b0) begin
            gen = rst_gen;
            repeat (C / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
               repeat (C) @(negedge clk);
               data[k] = tx_serial;
            end
            repeat (C) @(negedge clk);
            stop_bit = tx_serial;
            if (gen == rst_gen) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL frame: got unexpected byte %0h want none", data);
               end else begin
                  want = exp_q.pop_front();
                  check("frame_data", {24'b0, data}, {24'b0, want});
                  check("frame_stop", {31'b0, stop_bit}, 32'h1);
               end
            end
         end
      end
   end

   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
      bus_if.Address   = a;
      bus_if.WriteData = d;
      bus_if.MemWrite  = w;
      bus_if.MemRead   = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus_if.Address   = 32'h0;
      bus_if.WriteData = 32'h0;
      bus_if.MemWrite  = 1'b0;
      bus_if.MemRead   = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      idle(0);
      while (tx_busy !== 1'b0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      // Let the monitor finish sampling the last stop bit.
      idle(C);
      check("drain_timeout", {31'b0, tx_busy}, 32'h0);
   endtask

   initial begin
      logic [31:0] a;
      reset = 1'b1;
      idle(0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;

      // Reset state seen through a status read.
      drive(ST, 32'h0, 1'b0, 1'b1);
      idle(2);

      // Single byte 0xA5.
      drive(TX, 32'h0000_12A5, 1'b1, 1'b0);
      wait_idle(200);

      // Fill and overflow: 0x66 is dropped.
      for (int i = 1; i <= 6; i++) drive(TX, 32'(i * 8'h11), 1'b1, 1'b0);
      drive(ST, 32'h0, 1'b0, 1'b1);
      drive(ST, 32'h0, 1'b0, 1'b1);
      idle(10);
      drive(ST, 32'hFFFF_FFFF, 1'b1, 1'b0);
      drive(ST, 32'h0, 1'b0, 1'b1);
      wait_idle(600);
      drive(ST, 32'h0, 1'b0, 1'b1);

      // Address decode.
      drive(OTHER, 32'h0000_00C3, 1'b1, 1'b0);
      drive(OTHER, 32'h0, 1'b0, 1'b1);
      drive(ST, 32'h0, 1'b0, 1'b0);
      idle(5);
      check("decode_no_push", {31'b0, tx_busy}, 32'h0);

      // Reset in DATA bit 3 with two bytes queued; a store during reset is ignored.
      drive(TX, 32'h0000_003C, 1'b1, 1'b0);
      drive(TX, 32'h0000_0081, 1'b1, 1'b0);
      drive(TX, 32'h0000_00E7, 1'b1, 1'b0);
      idle(16);
      reset = 1'b1;
      drive(TX, 32'h0000_0077, 1'b1, 1'b0);
      reset = 1'b0;
      drive(ST, 32'h0, 1'b0, 1'b1);
      idle(100);

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 5))
            0, 1, 2: a = TX;
            3:       a = ST;
            4:       a = OTHER;
            default: a = $urandom();
         endcase
         drive(a, $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 60));
      end
      wait_idle(2000);
      check("all_bytes_sent", exp_q.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
